spi_mem_arbiter: RTL

- Single SPI master shared by two requesters: instruction fetch (PC-addressed program memory) and data access (MAR-addressed RAM).
- Arbitrates between them and sequences complete serial-SRAM transactions: command, 16-bit address, 1 data byte.
- Returns per-requester acknowledge and read data.
- Sits between the CU/PC/MAR datapath and the external SPI pins; `busy` stalls the divided execution clock.

---
 rtl/spi_mem_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_mem_arbiter.sv
// Shares one mode-0 SPI master between instruction fetch and data access,
// arbitrating round-robin and running one 32-bit serial-SRAM transaction at a time.
module spi_mem_arbiter #(
    parameter int unsigned CLK_DIV   = 2,
    parameter logic [7:0]  CMD_READ  = 8'h03,
    parameter logic [7:0]  CMD_WRITE = 8'h02
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic        fetch_ack,
    output logic [7:0]  fetch_data,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [15:0] data_addr,
    input  logic [7:0]  data_wdata,
    output logic        data_ack,
    output logic [7:0]  data_rdata,
    output logic        busy,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_rom_n,
    output logic        cs_ram_n
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam logic [3:0] HALF_LAST = 4'(CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 15) begin : g_bad_div
        $error("spi_mem_arbiter: CLK_DIV must be in 1..15");
    end

    state_e      state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  rx_q, rx_d;
    logic [4:0]  bit_q, bit_d;
    logic [3:0]  half_q, half_d;
    logic        sclk_q, sclk_d;
    logic        cs_rom_n_q, cs_rom_n_d;
    logic        cs_ram_n_q, cs_ram_n_d;
    logic        grant_data_q, grant_data_d;
    logic        write_q, write_d;
    logic        last_data_q, last_data_d;
    logic [7:0]  fetch_data_q, fetch_data_d;
    logic [7:0]  data_rdata_q, data_rdata_d;
    logic        pick_data;
    logic [7:0]  opcode;

    // State register: everything, including the SPI pins, comes straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= 32'h0;
            rx_q         <= 8'h00;
            bit_q        <= 5'd0;
            half_q       <= 4'd0;
            sclk_q       <= 1'b0;
            cs_rom_n_q   <= 1'b1;
            cs_ram_n_q   <= 1'b1;
            grant_data_q <= 1'b0;
            write_q      <= 1'b0;
            last_data_q  <= 1'b1;
            fetch_data_q <= 8'h00;
            data_rdata_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            rx_q         <= rx_d;
            bit_q        <= bit_d;
            half_q       <= half_d;
            sclk_q       <= sclk_d;
            cs_rom_n_q   <= cs_rom_n_d;
            cs_ram_n_q   <= cs_ram_n_d;
            grant_data_q <= grant_data_d;
            write_q      <= write_d;
            last_data_q  <= last_data_d;
            fetch_data_q <= fetch_data_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // Next state. sclk_q doubles as the phase flag: a half period ending with
    // sclk low raises it (and samples miso); one ending high starts the next bit.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        rx_d         = rx_q;
        bit_d        = bit_q;
        half_d       = half_q;
        sclk_d       = sclk_q;
        cs_rom_n_d   = cs_rom_n_q;
        cs_ram_n_d   = cs_ram_n_q;
        grant_data_d = grant_data_q;
        write_d      = write_q;
        last_data_d  = last_data_q;
        fetch_data_d = fetch_data_q;
        data_rdata_d = data_rdata_q;
        pick_data    = data_req && (!fetch_req || !last_data_q);
        opcode       = (pick_data && data_we) ? CMD_WRITE : CMD_READ;

        unique case (state_q)
            IDLE: begin
                if (fetch_req || data_req) begin
                    state_d      = SHIFT;
                    grant_data_d = pick_data;
                    last_data_d  = pick_data;
                    write_d      = pick_data && data_we;
                    shift_d      = {opcode,
                                    pick_data ? data_addr : fetch_addr,
                                    (pick_data && data_we) ? data_wdata : 8'h00};
                    cs_rom_n_d   = pick_data;
                    cs_ram_n_d   = !pick_data;
                    sclk_d       = 1'b0;
                    bit_d        = 5'd0;
                    half_d       = 4'd0;
                end
            end
            SHIFT: begin
                if (half_q != HALF_LAST) begin
                    half_d = half_q + 4'd1;
                end else begin
                    half_d = 4'd0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 5'd31) begin
                            state_d    = DONE;
                            shift_d    = 32'h0;
                            cs_rom_n_d = 1'b1;
                            cs_ram_n_d = 1'b1;
                            if (!write_q) begin
                                if (grant_data_q) begin
                                    data_rdata_d = rx_q;
                                end else begin
                                    fetch_data_d = rx_q;
                                end
                            end
                        end else begin
                            bit_d   = bit_q + 5'd1;
                            shift_d = {shift_q[30:0], 1'b0};
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: acks are decoded from DONE, mosi is the top of the shift register.
    always_comb begin
        fetch_ack  = 1'b0;
        data_ack   = 1'b0;
        if (state_q == DONE) begin
            fetch_ack = !grant_data_q;
            data_ack  = grant_data_q;
        end
        busy       = (state_q != IDLE);
        sclk       = sclk_q;
        mosi       = shift_q[31];
        cs_rom_n   = cs_rom_n_q;
        cs_ram_n   = cs_ram_n_q;
        fetch_data = fetch_data_q;
        data_rdata = data_rdata_q;
    end

endmodule
